// File: rtl/alu_ctrl_stage_pkg.sv
// alu_pkg: shared constants and types for the ID/EX ALU-control stage.
// ALU operation codes, ALUop encoding, funct7 classes and the M-op FSM states.
package alu_pkg;

    // E-stage ALU operation codes (4-bit core, zero-extended at the port)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MD   = 4'b1111;

    // funct7 classes for R-type instructions
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ILL   = 2'b11
    } aluop_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Shared funct3 map for the I-type and base R-type groups; only the
    // shift-right slot depends on the arithmetic bit (funct7[5]).
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic arith);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = arith ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// alu_ctrl_stage_if: D-stage decode inputs, hazard controls and E-stage outputs.
// Handshake: there is no valid/ready pair; ValidD qualifies the D-side fields, and
// the E register advances only when StallE, FlushE and MdStallE are all low
// (FlushE overrides and inserts a bubble). ValidE qualifies every E-side output.
interface alu_ctrl_stage_if #(
    parameter int ALUCTRL_W = 4
);
    import alu_pkg::*;

    logic                 StallE;
    logic                 FlushE;
    logic                 ValidD;
    logic [1:0]           ALUopD;
    logic [2:0]           funct3D;
    logic [6:0]           funct7D;
    logic                 op5D;

    logic [ALUCTRL_W-1:0] ALUControlE;
    logic                 ValidE;
    logic                 IllegalE;
    logic                 MdOpE;
    logic [2:0]           MdFunctE;
    logic                 MdStallE;
    logic                 MdDoneE;
    md_state_t            md_state_dbg;   // M-op sequencer state, observation only

    modport master (
        output StallE, FlushE, ValidD, ALUopD, funct3D, funct7D, op5D,
        input  ALUControlE, ValidE, IllegalE, MdOpE, MdFunctE, MdStallE, MdDoneE,
        input  md_state_dbg
    );

    modport slave (
        input  StallE, FlushE, ValidD, ALUopD, funct3D, funct7D, op5D,
        output ALUControlE, ValidE, IllegalE, MdOpE, MdFunctE, MdStallE, MdDoneE,
        output md_state_dbg
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: purely combinational ALU-control decode of a D-stage instruction.
// M-extension encodings decode only when RV32M_EN is defined; otherwise they are illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       op5_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o,
    output logic       md_op_o,
    output logic [2:0] md_funct_o
);

    // Decode ALUop/funct fields; illegal encodings fall back to add.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        md_op_o    = 1'b0;
        md_funct_o = 3'b000;
        case (aluop_t'(aluop_i))
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                if (!op5_i) begin
                    alu_ctrl_o = f3_to_alu(funct3_i, funct7_i[5]);
                end else if (funct7_i == FUNCT7_BASE) begin
                    alu_ctrl_o = f3_to_alu(funct3_i, 1'b0);
                end else if (funct7_i == FUNCT7_ALT) begin
                    if (funct3_i == 3'b000) begin
                        alu_ctrl_o = ALU_SUB;
                    end else if (funct3_i == 3'b101) begin
                        alu_ctrl_o = ALU_SRA;
                    end else begin
                        illegal_o = 1'b1;
                    end
`ifdef RV32M_EN
                end else if (funct7_i == FUNCT7_MULDIV) begin
                    alu_ctrl_o = ALU_MD;
                    md_op_o    = 1'b1;
                    md_funct_o = funct3_i;
`endif
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control decode at the ID/EX boundary, plus the
// multi-cycle M-op latency sequencer that requests pipeline stalls.
// Optional feature macro: RV32M_EN (M-extension decode, FSM and counter).
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 34,
    parameter int CNT_W     = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input logic              clk,
    input logic              rst_n,
    alu_ctrl_stage_if.slave  bus
);

    logic [3:0] dec_alu;
    logic       dec_illegal;
    logic       dec_md;
    logic [2:0] dec_funct;

    logic       valid_q,   valid_d;
    logic       illegal_q, illegal_d;
    logic [3:0] alu_q,     alu_d;
    logic       md_op_q,   md_op_d;
    logic [2:0] funct_q,   funct_d;

    logic       md_stall;
    logic       md_done;
    logic       load;
    logic       start;

    alu_ctrl_dec u_dec (
        .aluop_i    (bus.ALUopD),
        .funct3_i   (bus.funct3D),
        .funct7_i   (bus.funct7D),
        .op5_i      (bus.op5D),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_illegal),
        .md_op_o    (dec_md),
        .md_funct_o (dec_funct)
    );

    // E register advances only when nothing holds it; flush is handled separately.
    assign load  = !bus.FlushE && !bus.StallE && !md_stall;
    assign start = load && bus.ValidD && dec_md;

    // Next-state of the E register: flush bubble, hold, or load the D decode.
    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        alu_d     = alu_q;
        md_op_d   = md_op_q;
        funct_d   = funct_q;
        if (bus.FlushE || (load && !bus.ValidD)) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            alu_d     = ALU_ADD;
            md_op_d   = 1'b0;
            funct_d   = 3'b000;
        end else if (load) begin
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
            alu_d     = dec_alu;
            md_op_d   = dec_md;
            funct_d   = dec_funct;
        end
    end

    // E register state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            alu_q     <= ALU_ADD;
            md_op_q   <= 1'b0;
            funct_q   <= 3'b000;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            alu_q     <= alu_d;
            md_op_q   <= md_op_d;
            funct_q   <= funct_d;
        end
    end

`ifdef RV32M_EN
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done1_q, done1_d;   // done pulse for single-cycle M ops
    logic             start_lat1;

    assign start_lat1 = dec_funct[2] ? (DIV_LAT == 1) : (MUL_LAT == 1);

    // Stall while counting down; done on the last E cycle of the op.
    assign md_stall = (state_q == MD_BUSY) && (cnt_q != '0);
    assign md_done  = ((state_q == MD_BUSY) && (cnt_q == '0)) || done1_q;

    // Sequencer next-state: start on an M-op load, count down, abort on flush.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done1_d = 1'b0;
        if (bus.FlushE) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            if (start_lat1) begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                done1_d = 1'b1;
            end else begin
                state_d = MD_BUSY;
                cnt_d   = dec_funct[2] ? DIV_CNT : MUL_CNT;
            end
        end else if (state_q == MD_BUSY) begin
            if (cnt_q == '0) begin
                state_d = MD_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Sequencer state with asynchronous clear; a reset mid-op drops it to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done1_q <= done1_d;
        end
    end

    assign bus.md_state_dbg = state_q;
    assign bus.MdOpE        = md_op_q;
`else
    assign md_stall         = 1'b0;
    assign md_done          = 1'b0;
    assign bus.md_state_dbg = MD_IDLE;
    assign bus.MdOpE        = 1'b0;
    logic unused_md;
    assign unused_md = md_op_q ^ start;
`endif

    assign bus.ALUControlE = ALUCTRL_W'(alu_q);
    assign bus.ValidE      = valid_q;
    assign bus.IllegalE    = illegal_q;
    assign bus.MdFunctE    = funct_q;
    assign bus.MdStallE    = md_stall;
    assign bus.MdDoneE     = md_done;

endmodule
